hsid_x_band_unpacker: RTL and testbench

- Downstream consumer of the OBI memory reader's word stream (data_out_valid/data_out).
- Buffers incoming words in a small FIFO, splits each word into BAND_WIDTH spectral band samples (LSB first), and emits them on a ready/valid stream.
- Marks pixel boundaries with band_last; the distance/identification datapath consumes this stream.
- The memory reader has no backpressure, so this block absorbs stalls and flags overflow.

---
 rtl/hsid_pkg.sv | 21 ++
 rtl/hsid_x_band_unpacker_sva.sv | 68 ++++++
 rtl/hsid_x_sync_fifo.sv | 62 ++++++
 rtl/hsid_x_band_unpacker.sv | 222 ++++++++++++++++++++++
 tb/tb_hsid_x_band_unpacker.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hsid_pkg.sv
// -----------------------------------------------------------------------------
// hsid_pkg
// Shared constants and types for the hyperspectral identification pipeline.
//   HSID_WORD_WIDTH  : width of one word delivered by the memory reader
//   HSID_BAND_WIDTH  : width of one spectral band sample
//   hsid_x_band_unpacker_state_t : control states of the band unpacker
// -----------------------------------------------------------------------------
package hsid_pkg;

    localparam int HSID_WORD_WIDTH = 32;
    localparam int HSID_BAND_WIDTH = 16;

    typedef enum logic [2:0] {
        HXBU_IDLE   = 3'd0,
        HXBU_INIT   = 3'd1,
        HXBU_STREAM = 3'd2,
        HXBU_DONE   = 3'd3,
        HXBU_CLEAR  = 3'd4
    } hsid_x_band_unpacker_state_t;

endpackage : hsid_pkg

// File: rtl/hsid_x_band_unpacker_sva.sv
// -----------------------------------------------------------------------------
// hsid_x_band_unpacker_sva
// Protocol and consistency properties for hsid_x_band_unpacker, attached with
// bind so the design file carries no checking code.
//   clk, rst                : clock and reset of the bound block
//   clear, state            : control input and current FSM state
//   idle, ready, done       : status outputs
//   band_*                  : output stream
//   fifo_full, fifo_empty   : internal buffer status
// -----------------------------------------------------------------------------
module hsid_x_band_unpacker_sva
    import hsid_pkg::*;
#(
    parameter int BAND_WIDTH = HSID_BAND_WIDTH
) (
    input logic                        clk,
    input logic                        rst,
    input logic                        clear,
    input hsid_x_band_unpacker_state_t state,
    input logic                        idle,
    input logic                        ready,
    input logic                        done,
    input logic                        band_valid,
    input logic                        band_ready,
    input logic [BAND_WIDTH-1:0]       band_data,
    input logic                        band_last,
    input logic                        fifo_full,
    input logic                        fifo_empty
);

    a_status_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0({idle, ready, done}));

    a_idle_matches_state: assert property (@(posedge clk) disable iff (rst)
        idle == (state == HXBU_IDLE));

    a_valid_only_stream: assert property (@(posedge clk) disable iff (rst)
        band_valid |-> (state == HXBU_STREAM));

    a_last_needs_valid: assert property (@(posedge clk) disable iff (rst)
        band_last |-> band_valid);

    // A stalled sample must stay put until the consumer takes it.
    a_hold_while_stalled: assert property (@(posedge clk) disable iff (rst)
        (band_valid && !band_ready && !clear) |=> (band_valid && $stable(band_data)));

    a_fifo_status_sane: assert property (@(posedge clk) disable iff (rst)
        !(fifo_full && fifo_empty));

endmodule : hsid_x_band_unpacker_sva

bind hsid_x_band_unpacker hsid_x_band_unpacker_sva #(
    .BAND_WIDTH (BAND_WIDTH)
) u_sva (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .state      (state_q),
    .idle       (idle),
    .ready      (ready),
    .done       (done),
    .band_valid (band_valid),
    .band_ready (band_ready),
    .band_data  (band_data),
    .band_last  (band_last),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty)
);

// File: rtl/hsid_x_sync_fifo.sv
// -----------------------------------------------------------------------------
// hsid_x_sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// rd_data whenever empty is low; rd_en consumes it.
//   clk, rst  : clock and synchronous active-high reset
//   flush     : empties the FIFO at the next edge (dominates wr_en)
//   wr_en     : push wr_data; ignored when full unless a pop happens that cycle
//   rd_en     : pop the head entry; ignored when empty
//   rd_data   : head entry
//   empty/full: occupancy status
// -----------------------------------------------------------------------------
module hsid_x_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr;
    logic             do_rd;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    // A same-cycle pop frees the slot, so a write into a full FIFO still lands.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every always_ff reads the pre-edge value of every register.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_wr && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule : hsid_x_sync_fifo

// File: rtl/hsid_x_band_unpacker.sv
// -----------------------------------------------------------------------------
// hsid_x_band_unpacker
// Buffers words from the memory reader, splits each word into band samples
// (LSB first) and emits them on a ready/valid stream with pixel boundaries
// marked by band_last. The reader cannot be stalled, so words that find the
// buffer full are dropped and flagged on the sticky overflow output.
//   clk, rst            : clock and synchronous active-high reset
//   start / clear       : run control (clear dominates start)
//   pixel_bands         : bands per pixel, latched in INIT (0 means all-ones)
//   num_pixels          : pixels per run, latched in INIT (0 means all-ones)
//   data_in_valid/_in   : word stream from the memory reader
//   band_valid/_ready   : output handshake
//   band_data/band_last : band sample and end-of-pixel marker
//   overflow            : sticky word-dropped flag, cleared in INIT
//   idle / ready / done : status (IDLE / STREAM / DONE)
// -----------------------------------------------------------------------------
module hsid_x_band_unpacker
    import hsid_pkg::*;
#(
    parameter int WORD_WIDTH      = HSID_WORD_WIDTH,
    parameter int BAND_WIDTH      = HSID_BAND_WIDTH,
    parameter int FIFO_DEPTH      = 4,
    parameter int BAND_CNT_WIDTH  = 8,
    parameter int PIXEL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       clear,
    input  logic [BAND_CNT_WIDTH-1:0]  pixel_bands,
    input  logic [PIXEL_CNT_WIDTH-1:0] num_pixels,
    input  logic                       data_in_valid,
    input  logic [WORD_WIDTH-1:0]      data_in,
    output logic                       band_valid,
    input  logic                       band_ready,
    output logic [BAND_WIDTH-1:0]      band_data,
    output logic                       band_last,
    output logic                       overflow,
    output logic                       idle,
    output logic                       ready,
    output logic                       done
);

    localparam int ELEMS  = WORD_WIDTH / BAND_WIDTH;
    localparam int ELEM_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam int PIX_W  = PIXEL_CNT_WIDTH + 1;

    hsid_x_band_unpacker_state_t state_q;

    logic                       idle_q;
    logic                       ready_q;
    logic                       done_q;
    logic                       overflow_q;
    logic [BAND_CNT_WIDTH-1:0]  bands_q;
    logic [PIXEL_CNT_WIDTH-1:0] pixels_q;
    logic [BAND_CNT_WIDTH-1:0]  band_cnt_q;
    logic [BAND_CNT_WIDTH-1:0]  band_cnt_d;
    logic [ELEM_W-1:0]          elem_q;
    logic [ELEM_W-1:0]          elem_d;
    logic [PIX_W-1:0]           pix_cnt_q;
    logic [PIX_W-1:0]           pix_cnt_d;

    logic                       fifo_flush;
    logic                       fifo_wr_en;
    logic                       fifo_rd_en;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic [WORD_WIDTH-1:0]      fifo_rd_data;
    logic [ELEMS-1:0][BAND_WIDTH-1:0] head_elems;

    logic streaming;
    logic word_in;
    logic hs;
    logic elem_last;
    logic final_hs;
    logic ovf_event;

    // ---------------------------------------------------------------- datapath
    assign streaming  = (state_q == HXBU_STREAM);
    assign head_elems = fifo_rd_data;

    assign band_valid = streaming && !fifo_empty;
    assign band_last  = band_valid && (band_cnt_q == bands_q - BAND_CNT_WIDTH'(1));
    // Zeroed when idle so stale buffer contents never reach the consumer.
    assign band_data  = band_valid ? head_elems[elem_q] : '0;

    assign hs         = band_valid && band_ready;
    assign elem_last  = (elem_q == ELEM_W'(ELEMS - 1));
    assign final_hs   = hs && band_last && (pix_cnt_q + PIX_W'(1) == {1'b0, pixels_q});

    // Pixels are word aligned: the pixel's last band retires its word even if
    // upper elements remain unused.
    assign fifo_rd_en = hs && (elem_last || band_last);
    assign word_in    = streaming && data_in_valid;
    assign fifo_wr_en = word_in && (!fifo_full || fifo_rd_en);
    assign ovf_event  = word_in && fifo_full && !fifo_rd_en;
    // Leftover words after the final pixel are discarded on the way into DONE.
    assign fifo_flush = (state_q == HXBU_CLEAR) || final_hs;

    assign overflow   = overflow_q;
    assign idle       = idle_q;
    assign ready      = ready_q;
    assign done       = done_q;

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        band_cnt_d = band_cnt_q;
        elem_d     = elem_q;
        pix_cnt_d  = pix_cnt_q;
        if (hs) begin
            if (band_last) begin
                band_cnt_d = '0;
                elem_d     = '0;
                pix_cnt_d  = pix_cnt_q + PIX_W'(1);
            end else begin
                band_cnt_d = band_cnt_q + BAND_CNT_WIDTH'(1);
                elem_d     = elem_last ? '0 : elem_q + ELEM_W'(1);
            end
        end
    end

    // ------------------------------------------------------------ control FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HXBU_IDLE;
            idle_q     <= 1'b1;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            bands_q    <= '0;
            pixels_q   <= '0;
            band_cnt_q <= '0;
            elem_q     <= '0;
            pix_cnt_q  <= '0;
        end else begin
            case (state_q)
                HXBU_IDLE: begin
                    if (start && !clear) begin
                        state_q <= HXBU_INIT;
                        idle_q  <= 1'b0;
                    end
                end
                HXBU_INIT: begin
                    if (clear) begin
                        state_q    <= HXBU_CLEAR;
                        overflow_q <= 1'b0;
                    end else begin
                        bands_q    <= (pixel_bands == '0) ? '1 : pixel_bands;
                        pixels_q   <= (num_pixels == '0) ? '1 : num_pixels;
                        band_cnt_q <= '0;
                        elem_q     <= '0;
                        pix_cnt_q  <= '0;
                        overflow_q <= 1'b0;
                        state_q    <= HXBU_STREAM;
                        ready_q    <= 1'b1;
                    end
                end
                HXBU_STREAM: begin
                    if (clear) begin
                        state_q    <= HXBU_CLEAR;
                        ready_q    <= 1'b0;
                        overflow_q <= 1'b0;
                    end else begin
                        band_cnt_q <= band_cnt_d;
                        elem_q     <= elem_d;
                        pix_cnt_q  <= pix_cnt_d;
                        if (ovf_event) overflow_q <= 1'b1;
                        if (final_hs) begin
                            state_q <= HXBU_DONE;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                HXBU_DONE: begin
                    if (clear) begin
                        state_q    <= HXBU_CLEAR;
                        done_q     <= 1'b0;
                        overflow_q <= 1'b0;
                    end else if (start) begin
                        state_q <= HXBU_INIT;
                        done_q  <= 1'b0;
                    end
                end
                HXBU_CLEAR: begin
                    state_q    <= HXBU_IDLE;
                    idle_q     <= 1'b1;
                    overflow_q <= 1'b0;
                    bands_q    <= '0;
                    pixels_q   <= '0;
                    band_cnt_q <= '0;
                    elem_q     <= '0;
                    pix_cnt_q  <= '0;
                end
                default: begin
                    state_q <= HXBU_IDLE;
                    idle_q  <= 1'b1;
                    ready_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------ word buffer
    hsid_x_sync_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (fifo_flush),
        .wr_en   (fifo_wr_en),
        .wr_data (data_in),
        .rd_en   (fifo_rd_en),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

endmodule : hsid_x_band_unpacker

// File: tb/tb_hsid_x_band_unpacker.sv
// -----------------------------------------------------------------------------
// tb_hsid_x_band_unpacker
// Self-checking bench for hsid_x_band_unpacker. Expected band sequences are
// derived from the word list with plain arithmetic (word index, half select,
// pixel alignment) and compared on each output handshake.
// -----------------------------------------------------------------------------
module tb_hsid_x_band_unpacker;

    localparam int WW    = 32;
    localparam int BW    = 16;
    localparam int ELEMS = WW / BW;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic          clear;
    logic [7:0]    pixel_bands;
    logic [15:0]   num_pixels;
    logic          data_in_valid;
    logic [WW-1:0] data_in;
    logic          band_valid;
    logic          band_ready;
    logic [BW-1:0] band_data;
    logic          band_last;
    logic          overflow;
    logic          idle;
    logic          ready;
    logic          done;

    int total = 0;
    int bad   = 0;

    logic [WW-1:0] words[$];

    hsid_x_band_unpacker dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .clear         (clear),
        .pixel_bands   (pixel_bands),
        .num_pixels    (num_pixels),
        .data_in_valid (data_in_valid),
        .data_in       (data_in),
        .band_valid    (band_valid),
        .band_ready    (band_ready),
        .band_data     (band_data),
        .band_last     (band_last),
        .overflow      (overflow),
        .idle          (idle),
        .ready         (ready),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int b, input int p, input string tag);
        pixel_bands = 8'(b);
        num_pixels  = 16'(p);
        start       = 1'b1;
        step();
        start       = 1'b0;
        check({tag, "_init_status"}, {idle, ready, done}, 3'b000);
        step();
        check({tag, "_stream_status"}, {idle, ready, done}, 3'b010);
        check({tag, "_init_ovf_clear"}, overflow, 0);
    endtask

    // Runs one stream: words[] supplies the input, the expected band list is
    // computed from the band/pixel counts, handshakes are checked in order.
    task automatic run(input int b_drive, input int p_drive, input int b_eff, input int p_eff,
                       input int max_bands, input int extra, input int rdy_pct,
                       input int vld_pct, input bit expect_done, input string tag);
        logic [BW-1:0] exp_data[$];
        bit            exp_last[$];
        bit            exp_pop[$];
        int            nwords;
        int            base;
        int            nb;
        int            sent;
        int            popped;
        int            cyc;
        int            per;
        int            budget;
        nwords = 0;
        base   = 0;
        nb     = 0;
        sent   = 0;
        popped = 0;
        cyc    = 0;
        per    = (b_eff + ELEMS - 1) / ELEMS;
        budget = max_bands * 40 + 100;
        for (int p = 0; p < p_eff && nb < max_bands; p++) begin
            for (int b = 0; b < b_eff && nb < max_bands; b++) begin
                int            idx;
                logic [WW-1:0] w;
                idx = base + b / ELEMS;
                while (words.size() <= idx) words.push_back($urandom);
                w = words[idx] >> (BW * (b % ELEMS));
                exp_data.push_back(w[BW-1:0]);
                exp_last.push_back(b == b_eff - 1);
                exp_pop.push_back((b % ELEMS == ELEMS - 1) || (b == b_eff - 1));
                nwords = idx + 1;
                nb++;
            end
            base += per;
        end
        while (words.size() < nwords + extra) words.push_back($urandom);

        start_run(b_drive, p_drive, tag);
        while (exp_data.size() > 0) begin
            if (cyc > budget) begin
                check({tag, "_timeout"}, 0, 1);
                break;
            end
            cyc++;
            band_ready = ($urandom_range(99) < rdy_pct);
            if (band_valid && band_ready) begin
                check({tag, "_data"}, band_data, exp_data.pop_front());
                check({tag, "_last"}, band_last, exp_last.pop_front());
                if (exp_pop.pop_front()) popped++;
            end
            if (sent < words.size() && (sent - popped) < DEPTH &&
                $urandom_range(99) < vld_pct) begin
                data_in_valid = 1'b1;
                data_in       = words[sent];
                sent++;
            end else begin
                data_in_valid = 1'b0;
                data_in       = $urandom;
            end
            step();
        end
        data_in_valid = 1'b0;
        band_ready    = 1'b0;
        check({tag, "_no_overflow"}, overflow, 0);
        if (expect_done) begin
            check({tag, "_done"}, {idle, ready, done}, 3'b001);
            check({tag, "_done_no_valid"}, band_valid, 0);
        end
    endtask

    initial begin
        logic [WW-1:0] ovw[5];
        logic [WW-1:0] t;

        rst           = 1'b1;
        start         = 1'b0;
        clear         = 1'b0;
        pixel_bands   = '0;
        num_pixels    = '0;
        data_in_valid = 1'b0;
        data_in       = '0;
        band_ready    = 1'b0;
        step();
        step();
        check("reset_status", {idle, ready, done}, 3'b100);
        check("reset_outputs", {band_valid, band_last, overflow}, 3'b000);
        check("reset_band_data", band_data, 0);
        rst = 1'b0;
        step();
        check("post_reset_idle", idle, 1);

        // Four bands per pixel, two pixels, consumer always ready.
        words = '{32'h0002_0001, 32'h0004_0003, 32'h0006_0005, 32'h0008_0007};
        run(4, 2, 4, 2, 8, 0, 100, 100, 1'b1, "tp1");

        // Odd band count: upper half of each pixel's last word is discarded.
        words = '{32'hAAAA_0001, 32'hDEAD_0002, 32'h0003_0004, 32'h0005_0006};
        run(3, 2, 3, 2, 6, 0, 100, 100, 1'b1, "tp2");

        // Stalled consumer while five words arrive back to back.
        for (int i = 0; i < 5; i++) ovw[i] = $urandom;
        start_run(8, 1, "ovf");
        band_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_in_valid = 1'b1;
            data_in       = ovw[i];
            step();
            if (i == 0) begin
                check("ovf_latency_valid", band_valid, 1);
                check("ovf_first_band", band_data, {16'h0, ovw[0][15:0]});
            end
            if (i == 3) check("ovf_full_no_flag", overflow, 0);
        end
        data_in_valid = 1'b0;
        check("ovf_flag", overflow, 1);
        check("ovf_stall_data", band_data, {16'h0, ovw[0][15:0]});
        step();
        check("ovf_sticky", overflow, 1);
        band_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            t = ovw[b / 2] >> (16 * (b % 2));
            check("ovf_drain_data", band_data, {16'h0, t[15:0]});
            check("ovf_drain_last", band_last, (b == 7));
            step();
        end
        band_ready = 1'b0;
        check("ovf_done", done, 1);
        check("ovf_sticky_in_done", overflow, 1);

        // Restart straight from DONE: INIT must clear overflow.
        words.delete();
        run(5, 2, 5, 2, 10, 1, 70, 80, 1'b1, "restart");

        // clear from DONE, then start+clear together in IDLE.
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_done_status", {idle, ready, done}, 3'b000);
        step();
        check("clr_done_idle", {idle, ready, done}, 3'b100);
        start = 1'b1;
        clear = 1'b1;
        step();
        check("start_clear_idle", {idle, ready, done}, 3'b100);
        step();
        check("start_clear_idle2", {idle, ready, done}, 3'b100);
        start = 1'b0;
        clear = 1'b0;

        // clear mid-stream with two words buffered.
        start_run(8, 1, "clrmid");
        band_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            data_in_valid = 1'b1;
            data_in       = $urandom;
            step();
        end
        data_in_valid = 1'b0;
        check("clrmid_buffered", band_valid, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clrmid_clear_status", {idle, ready, done}, 3'b000);
        check("clrmid_clear_valid", band_valid, 0);
        step();
        check("clrmid_idle_status", {idle, ready, done}, 3'b100);
        check("clrmid_idle_valid", band_valid, 0);

        // Randomized runs; the first one proves the buffer was emptied.
        for (int r = 0; r < 6; r++) begin
            int b;
            int p;
            b = $urandom_range(7, 1);
            p = $urandom_range(3, 1);
            words.delete();
            run(b, p, b, p, b * p, $urandom_range(2, 0), $urandom_range(100, 30),
                $urandom_range(100, 30), 1'b1, "rand");
        end

        // Zero limits latch as all-ones: 255 bands per pixel, then reset mid-pixel.
        words.delete();
        run(0, 0, 255, 2, 258, 0, 100, 100, 1'b0, "allones");
        check("allones_still_stream", ready, 1);
        rst = 1'b1;
        step();
        check("rst_mid_status", {idle, ready, done}, 3'b100);
        check("rst_mid_outputs", {band_valid, band_last, overflow}, 3'b000);
        check("rst_mid_band_data", band_data, 0);
        rst = 1'b0;
        step();
        check("rst_mid_idle", idle, 1);
        check("rst_mid_no_valid", band_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hsid_x_band_unpacker
